// File: rtl/hazard_pkg.sv
// Shared encodings for the five-stage pipeline hazard controller:
// FSM states, forwarding select codes and the ID/EX NOP control word.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int          CTRL_W   = 18;
    localparam logic [17:0] NOP_CTRL = 18'b0;

endpackage

// File: rtl/forwarding_unit.sv
// Per-operand forwarding select: MEM result beats WB result, r0 never forwards.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_rf_enable && (mem_rd != 5'd0) && (mem_rd == src_reg);
        wb_hit  = wb_rf_enable  && (wb_rd  != 5'd0) && (wb_rd  == src_reg);
        fwd_sel = FWD_RF;
        if (mem_hit)
            fwd_sel = FWD_MEM;
        else if (wb_hit)
            fwd_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage MIPS pipeline: stall/bubble/flush
// sequencing, ID-stage forwarding selects and a saturating stall counter.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instr,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rf_enable,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rf_enable,
    input  logic             ex_branch_taken,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mem_busy;

    always_comb begin
        load_use = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) ||
                    (id_uses_rt && (id_rt == ex_rd)));
        mem_busy = ~dmem_ready;
    end

    // Outputs depend only on the live hazard terms: once a freeze ends the
    // pipeline re-evaluates exactly as in RUN, so state only steers next-state.
    always_comb begin
        state_d       = RUN;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;

        if (mem_busy) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            state_d       = MEM_WAIT;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            // The delay slot still consumes the load result, so hold it in ID.
            if (load_use) begin
                if_id_enable = 1'b0;
                id_ex_bubble = 1'b1;
            end
            state_d = RUN;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = (state_q == LD_STALL) ? RUN : LD_STALL;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_enable && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

    forwarding_unit u_fwd_a (
        .src_reg       (id_rs),
        .mem_rd        (mem_rd),
        .mem_rf_enable (mem_rf_enable),
        .wb_rd         (wb_rd),
        .wb_rf_enable  (wb_rf_enable),
        .fwd_sel       (fwd_a_sel)
    );

    forwarding_unit u_fwd_b (
        .src_reg       (id_rt),
        .mem_rd        (mem_rd),
        .mem_rf_enable (mem_rf_enable),
        .wb_rd         (wb_rd),
        .wb_rf_enable  (wb_rf_enable),
        .fwd_sel       (fwd_b_sel)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; a CNT_W=4 twin shares the inputs
// to exercise counter saturation.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0, mem_rd = 5'd0, wb_rd = 5'd0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       ex_rf_enable = 1'b0, ex_load_instr = 1'b0;
    logic       mem_rf_enable = 1'b0, wb_rf_enable = 1'b0;
    logic       ex_branch_taken = 1'b0, dmem_ready = 1'b1;

    logic        pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_enable, mem_wb_enable;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cycles;

    logic        s_pc, s_ifid, s_flush, s_bub, s_exm, s_mwb;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  s_stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
        .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
        .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
    );

    hazard_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
        .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
        .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .pc_enable(s_pc), .if_id_enable(s_ifid), .if_id_flush(s_flush),
        .id_ex_bubble(s_bub), .ex_mem_enable(s_exm), .mem_wb_enable(s_mwb),
        .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall_cycles(s_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rf_enable = 1'b0; ex_load_instr = 1'b0;
        mem_rf_enable = 1'b0; wb_rf_enable = 1'b0;
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        check("rst_pc_en", 32'(pc_enable), 32'd1);
        step();
        reset = 1'b0;
        #1;

        // Load-use: load r5 in EX, ID reads r5 as rs
        ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1;
        #1;
        check("lu_pc_en", 32'(pc_enable), 32'd0);
        check("lu_ifid_en", 32'(if_id_enable), 32'd0);
        check("lu_bubble", 32'(id_ex_bubble), 32'd1);
        check("lu_exmem_en", 32'(ex_mem_enable), 32'd1);
        step();
        check("lu_state", 32'(dut.state_q), 32'd1);
        check("lu_stall1", 32'(stall_cycles), 32'd1);
        // Load now in MEM, bubble in EX
        ex_load_instr = 1'b0; ex_rf_enable = 1'b0; ex_rd = 5'd0;
        mem_rd = 5'd5; mem_rf_enable = 1'b1;
        #1;
        check("lu_fwd_a", 32'(fwd_a_sel), 32'd1);
        check("lu2_pc_en", 32'(pc_enable), 32'd1);
        check("lu2_bubble", 32'(id_ex_bubble), 32'd0);
        step();
        check("lu_back_run", 32'(dut.state_q), 32'd0);
        check("lu_stall_hold", 32'(stall_cycles), 32'd1);

        // load on r0 never stalls
        clear_inputs();
        ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd0;
        id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        check("lu_r0_pc_en", 32'(pc_enable), 32'd1);
        // Match on rt but rt not used: no stall
        ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0; id_rs = 5'd1;
        #1;
        check("lu_unused_rt", 32'(id_ex_bubble), 32'd0);
        id_uses_rt = 1'b1;
        #1;
        check("lu_rt_bubble", 32'(id_ex_bubble), 32'd1);

        // Forwarding priority and r0 exclusion
        clear_inputs();
        id_rt = 5'd3; mem_rd = 5'd3; mem_rf_enable = 1'b1; wb_rd = 5'd3; wb_rf_enable = 1'b1;
        #1;
        check("fwd_b_mem", 32'(fwd_b_sel), 32'd1);
        mem_rd = 5'd0;
        #1;
        check("fwd_b_wb_r0", 32'(fwd_b_sel), 32'd2);
        mem_rd = 5'd3; mem_rf_enable = 1'b0;
        #1;
        check("fwd_b_wb_noen", 32'(fwd_b_sel), 32'd2);
        wb_rf_enable = 1'b0;
        #1;
        check("fwd_b_rf", 32'(fwd_b_sel), 32'd0);
        id_rs = 5'd0; mem_rd = 5'd0; mem_rf_enable = 1'b1; wb_rd = 5'd0; wb_rf_enable = 1'b1;
        #1;
        check("fwd_a_r0", 32'(fwd_a_sel), 32'd0);
        id_rs = 5'd9; wb_rd = 5'd9;
        #1;
        check("fwd_a_wb", 32'(fwd_a_sel), 32'd2);

        // Taken branch, no hazard, then with load-use on the delay slot
        clear_inputs();
        ex_branch_taken = 1'b1;
        #1;
        check("br_flush", 32'(if_id_flush), 32'd1);
        check("br_pc_en", 32'(pc_enable), 32'd1);
        check("br_bubble", 32'(id_ex_bubble), 32'd0);
        check("br_ifid_en", 32'(if_id_enable), 32'd1);
        ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        #1;
        check("brlu_flush", 32'(if_id_flush), 32'd1);
        check("brlu_bubble", 32'(id_ex_bubble), 32'd1);
        check("brlu_ifid_en", 32'(if_id_enable), 32'd0);
        check("brlu_pc_en", 32'(pc_enable), 32'd1);

        // Memory wait of 3 cycles over a taken branch
        clear_inputs();
        do_reset();
        ex_branch_taken = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_pc_en", 32'(pc_enable), 32'd0);
            check("mw_ifid_en", 32'(if_id_enable), 32'd0);
            check("mw_exmem_en", 32'(ex_mem_enable), 32'd0);
            check("mw_memwb_en", 32'(mem_wb_enable), 32'd0);
            check("mw_flush", 32'(if_id_flush), 32'd0);
            check("mw_bubble", 32'(id_ex_bubble), 32'd0);
            step();
        end
        check("mw_state", 32'(dut.state_q), 32'd2);
        dmem_ready = 1'b1;
        #1;
        check("mw_end_flush", 32'(if_id_flush), 32'd1);
        check("mw_end_pc_en", 32'(pc_enable), 32'd1);
        check("mw_stall3", 32'(stall_cycles), 32'd3);
        step();
        check("mw_stall_hold", 32'(stall_cycles), 32'd3);
        check("mw_run", 32'(dut.state_q), 32'd0);

        // Asynchronous reset in the middle of MEM_WAIT
        clear_inputs();
        dmem_ready = 1'b0;
        step();
        step();
        check("ar_pre_stall", 32'(stall_cycles), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("ar_stall0", 32'(stall_cycles), 32'd0);
        check("ar_state_run", 32'(dut.state_q), 32'd0);
        dmem_ready = 1'b1;
        step();
        reset = 1'b0;
        #1;

        // Saturation: 20 held load-use cycles on both counter widths
        ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd6; id_rs = 5'd6; id_uses_rs = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt4", 32'(s_stall), 32'd15);
        check("sat_cnt16", 32'(stall_cycles), 32'd20);
        clear_inputs();
        step();
        check("sat_hold4", 32'(s_stall), 32'd15);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the five-stage MIPS core (IF, ID, EX, MEM, WB). It sequences the pipeline registers and produces the hold, bubble and flush controls:
- PC and IF/ID hold on load-use hazards and data-memory wait.
- Bubble insertion into ID/EX.
- IF/ID squash when a taken branch resolves in EX.

It also drives the ID-stage operand-forwarding selects and keeps a saturating stall-cycle counter. It sits beside the pipeline registers and feeds their enable and clear inputs.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  source register rs of the instruction in ID.
- id_rt  in  5  source register rt of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_rf_enable  in  1  EX instruction writes the register file.
- ex_load_instr  in  1  EX instruction is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_rf_enable  in  1  MEM instruction writes the register file.
- wb_rd  in  5  destination register of the instruction in WB.
- wb_rf_enable  in  1  WB instruction writes the register file.
- ex_branch_taken  in  1  branch or jump in EX resolved taken.
- dmem_ready  in  1  data memory has completed the MEM-stage access.
- pc_enable  out  1  PC register load enable.
- if_id_enable  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID to a NOP on the next edge.
- id_ex_bubble  out  1  load all-zero control signals (18'b0) into ID/EX.
- ex_mem_enable  out  1  EX/MEM load enable.
- mem_wb_enable  out  1  MEM/WB load enable.
- fwd_a_sel  out  2  rs operand source: 00 register file, 01 MEM result, 10 WB result.
- fwd_b_sel  out  2  rt operand source, same encoding as fwd_a_sel.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_enable low.

## Operation
FSM states:
- RUN: normal flow.
- LD_STALL: one-cycle load-use bubble.
- MEM_WAIT: full freeze while data memory is busy.

Hazard terms, all combinational from the current inputs:
- load_use = ex_load_instr & ex_rf_enable & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- mem_busy = ~dmem_ready.

Event priority is fixed: mem_busy > ex_branch_taken > load_use.
- mem_busy asserted: every enable is low, no bubble, no flush, next state MEM_WAIT. The branch or load-use decision is taken only after the freeze ends.
- ex_branch_taken (no mem_busy): pc_enable=1, if_id_flush=1, the instruction in ID (delay slot) proceeds. If load_use is also true, id_ex_bubble=1 and if_id_enable=0, because the delay slot still needs the load data.
- load_use alone: pc_enable=0, if_id_enable=0, id_ex_bubble=1, next state LD_STALL.

State transitions:
- LD_STALL returns to RUN unconditionally next cycle, unless mem_busy, which sends it to MEM_WAIT. By then the load is in MEM and the forward comes from MEM.
- MEM_WAIT stays while dmem_ready=0 and re-evaluates as RUN on the cycle dmem_ready=1.

Forwarding, applied per operand:
- Select 01 when mem_rf_enable, mem_rd≠0 and the register numbers match.
- Otherwise select 10 when wb_rf_enable, wb_rd≠0 and they match.
- Otherwise select 00.
- MEM has priority over WB.
- Register 0 is never forwarded.
- Selects are independent of FSM state.

stall_cycles:
- Increments on each clock edge where pc_enable=0.
- Holds at all-ones (no wrap).

## Timing
- State and stall_cycles are registered; all other outputs are combinational from state and inputs (zero-cycle latency), sampled by the pipeline registers at the same edge.
- Reset, asynchronous: state=RUN and stall_cycles=0. While reset is high, the outputs take the RUN values for the current inputs.
- Load-use costs exactly 1 bubble cycle.
- Taken branch costs 1 squashed fetch.
- A memory wait of N cycles costs N frozen cycles.
- Reset asserted mid-stall returns to RUN immediately. There is no pending-stall memory.

## Structure
- hazard_pkg holds:
  - state encoding (RUN=2'd0, LD_STALL=2'd1, MEM_WAIT=2'd2);
  - forwarding select constants FWD_RF, FWD_MEM, FWD_WB;
  - the NOP control-word constant (18'b0).
- One sub-module, forwarding_unit: purely combinational, instantiated once per operand (rs, rt).

## Test plan
- Load r5 in EX, ID reads r5 as rs → cycle 0: pc_enable=0, if_id_enable=0, id_ex_bubble=1. Next cycle: RUN, fwd_a_sel=01. stall_cycles=1.
- mem_rd=r3 with mem_rf_enable=1 and wb_rd=r3 with wb_rf_enable=1, ID reads r3 as rt → fwd_b_sel=01. Same case with mem_rd=r0 or mem_rf_enable=0 → fwd_b_sel=10.
- ex_branch_taken=1 with no hazard → if_id_flush=1, pc_enable=1, id_ex_bubble=0. Add a load-use on the delay slot → if_id_flush=1, id_ex_bubble=1, if_id_enable=0.
- dmem_ready=0 for 3 cycles while ex_branch_taken=1 → all enables 0 for 3 cycles, no flush. On the cycle dmem_ready=1: if_id_flush=1. stall_cycles=3.
- Assert reset asynchronously during MEM_WAIT → state RUN and stall_cycles=0 before the next edge.
- CNT_W=4, hold a load-use stall repeatedly for 20 cycles → stall_cycles saturates at 15.
